// File: rtl/fft_sample_loader.sv
// Frame loader for the FFT front end: reads N_POINTS words from a synchronous ROM,
// converts them to fixed point, optionally bit-reverses slot order, and presents the frame under valid/ready.
module fft_sample_loader #(
  parameter int N_POINTS = 8,
  parameter int ROM_AW   = 3,
  parameter int ROM_DW   = 16,
  parameter int IN_W     = 8,
  parameter int FRAC_W   = 8,
  parameter int OUT_W    = 32,
  parameter int SIGNED   = 0
) (
  input  logic                      clk,
  input  logic                      reset_n,
  input  logic                      start,
  input  logic [ROM_AW-1:0]         base_addr,
  input  logic                      bitrev,
  output logic                      rom_en,
  output logic [ROM_AW-1:0]         rom_addr,
  input  logic [ROM_DW-1:0]         rom_data,
  output logic [N_POINTS*OUT_W-1:0] x_flat,
  output logic                      out_valid,
  input  logic                      out_ready,
  output logic                      busy,
  output logic [1:0]                state_dbg
);

  localparam int LOG2N = $clog2(N_POINTS);
  localparam int KW    = LOG2N + 1;
  localparam int SW    = OUT_W - FRAC_W;

  // Handshake: the frame on x_flat transfers on a rising edge where out_valid && out_ready;
  // out_valid never drops before that edge, and x_flat is stable while out_valid is high.
  typedef enum logic [1:0] {IDLE = 2'd0, FETCH = 2'd1, LAST = 2'd2, DONE = 2'd3} state_t;

  state_t            state, state_nx;
  logic [ROM_AW-1:0] base_q, base_nx;
  logic              bitrev_q, bitrev_nx;
  logic [KW-1:0]     k_q, k_nx;
  logic [LOG2N-1:0]  iss_slot, iss_slot_nx;
  logic              rom_en_nx;
  logic [ROM_AW-1:0] rom_addr_nx;
  logic              out_valid_nx;
  logic              p1_valid;
  logic [LOG2N-1:0]  p1_slot;
  logic [IN_W-1:0]   s_raw;
  logic [SW-1:0]     s_ext;
  logic [OUT_W-1:0]  sample;
  logic              unused_rom_bits;

  assign state_dbg       = state;
  assign unused_rom_bits = ^rom_data;

  function automatic logic [LOG2N-1:0] slot_of(input logic [LOG2N-1:0] idx, input logic rev);
    logic [LOG2N-1:0] r;
    for (int i = 0; i < LOG2N; i++)
      r[i] = rev ? idx[LOG2N-1-i] : idx[i];
    return r;
  endfunction

  always_comb begin
    s_raw = rom_data[IN_W-1:0];
    if (SIGNED != 0) s_ext = SW'($signed(s_raw));
    else             s_ext = SW'(s_raw);
    sample = OUT_W'(s_ext) << FRAC_W;
  end

  // State and output registers; a ROM word is captured two edges after its address is registered.
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      state     <= IDLE;
      base_q    <= '0;
      bitrev_q  <= 1'b0;
      k_q       <= '0;
      iss_slot  <= '0;
      rom_en    <= 1'b0;
      rom_addr  <= '0;
      out_valid <= 1'b0;
      busy      <= 1'b0;
      p1_valid  <= 1'b0;
      p1_slot   <= '0;
      x_flat    <= '0;
    end else begin
      state     <= state_nx;
      base_q    <= base_nx;
      bitrev_q  <= bitrev_nx;
      k_q       <= k_nx;
      iss_slot  <= iss_slot_nx;
      rom_en    <= rom_en_nx;
      rom_addr  <= rom_addr_nx;
      out_valid <= out_valid_nx;
      busy      <= (state_nx != IDLE);
      p1_valid  <= rom_en;
      p1_slot   <= iss_slot;
      if (p1_valid)
        x_flat[p1_slot*OUT_W +: OUT_W] <= sample;
    end
  end

  always_comb begin
    state_nx = state;
    case (state)
      IDLE:    if (start) state_nx = FETCH;
      FETCH:   if (k_q == KW'(N_POINTS)) state_nx = LAST;
      LAST:    state_nx = DONE;
      DONE:    if (out_ready) state_nx = IDLE;
      default: state_nx = IDLE;
    endcase
  end

  // Word 0 is issued on the start edge itself, so k counts words already issued.
  always_comb begin
    base_nx      = base_q;
    bitrev_nx    = bitrev_q;
    k_nx         = k_q;
    iss_slot_nx  = iss_slot;
    rom_en_nx    = 1'b0;
    rom_addr_nx  = rom_addr;
    out_valid_nx = out_valid;
    case (state)
      IDLE: begin
        if (start) begin
          base_nx     = base_addr;
          bitrev_nx   = bitrev;
          rom_en_nx   = 1'b1;
          rom_addr_nx = base_addr;
          iss_slot_nx = '0;
          k_nx        = KW'(1);
        end
      end
      FETCH: begin
        if (k_q != KW'(N_POINTS)) begin
          rom_en_nx   = 1'b1;
          rom_addr_nx = base_q + ROM_AW'(k_q);
          iss_slot_nx = slot_of(k_q[LOG2N-1:0], bitrev_q);
          k_nx        = k_q + KW'(1);
        end
      end
      LAST:    out_valid_nx = 1'b1;
      DONE:    if (out_ready) out_valid_nx = 1'b0;
      default: out_valid_nx = 1'b0;
    endcase
  end

endmodule

// File: tb/tb_fft_sample_loader.sv
// Bench for fft_sample_loader: three configurations (N=8/AW=3, N=16/AW=4, N=2/AW=5 signed)
// sharing one ROM model, a slot scoreboard and a table of spot checks.
module tb_fft_sample_loader;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic       reset_n, start, bitrev, out_ready;
  logic [4:0] base;
  int         sel;
  int         n_checks = 0;
  int         n_fail = 0;
  logic [31:0] exp_q[$];

  logic         start_a, rom_en_a, out_valid_a, busy_a;
  logic [2:0]   rom_addr_a;
  logic [15:0]  rom_data_a = '0;
  logic [255:0] x_flat_a;
  logic [1:0]   state_dbg_a;
  logic         start_b, rom_en_b, out_valid_b, busy_b;
  logic [3:0]   rom_addr_b;
  logic [15:0]  rom_data_b = '0;
  logic [511:0] x_flat_b;
  logic [1:0]   state_dbg_b;
  logic         start_c, rom_en_c, out_valid_c, busy_c;
  logic [4:0]   rom_addr_c;
  logic [15:0]  rom_data_c = '0;
  logic [63:0]  x_flat_c;
  logic [1:0]   state_dbg_c;

  assign start_a = start && (sel == 0);
  assign start_b = start && (sel == 1);
  assign start_c = start && (sel == 2);

  fft_sample_loader #(.N_POINTS(8), .ROM_AW(3)) dut_a (
    .clk(clk), .reset_n(reset_n), .start(start_a), .base_addr(base[2:0]), .bitrev(bitrev),
    .rom_en(rom_en_a), .rom_addr(rom_addr_a), .rom_data(rom_data_a), .x_flat(x_flat_a),
    .out_valid(out_valid_a), .out_ready(out_ready), .busy(busy_a), .state_dbg(state_dbg_a));

  fft_sample_loader #(.N_POINTS(16), .ROM_AW(4)) dut_b (
    .clk(clk), .reset_n(reset_n), .start(start_b), .base_addr(base[3:0]), .bitrev(bitrev),
    .rom_en(rom_en_b), .rom_addr(rom_addr_b), .rom_data(rom_data_b), .x_flat(x_flat_b),
    .out_valid(out_valid_b), .out_ready(out_ready), .busy(busy_b), .state_dbg(state_dbg_b));

  fft_sample_loader #(.N_POINTS(2), .ROM_AW(5), .SIGNED(1)) dut_c (
    .clk(clk), .reset_n(reset_n), .start(start_c), .base_addr(base), .bitrev(bitrev),
    .rom_en(rom_en_c), .rom_addr(rom_addr_c), .rom_data(rom_data_c), .x_flat(x_flat_c),
    .out_valid(out_valid_c), .out_ready(out_ready), .busy(busy_c), .state_dbg(state_dbg_c));

  function automatic logic [15:0] rom_word(input logic [4:0] a);
    if (a < 5'd16)  return {8'hFF, 8'h10 + {4'b0, a[3:0]}};
    if (a == 5'h1E) return 16'h0080;
    if (a == 5'h1F) return 16'h007F;
    return 16'h0000;
  endfunction

  always @(posedge clk) if (rom_en_a) rom_data_a <= rom_word(5'(rom_addr_a));
  always @(posedge clk) if (rom_en_b) rom_data_b <= rom_word(5'(rom_addr_b));
  always @(posedge clk) if (rom_en_c) rom_data_c <= rom_word(rom_addr_c);

  logic         cur_en, cur_valid, cur_busy;
  logic [4:0]   cur_addr;
  logic [511:0] cur_x;
  always_comb begin
    cur_en = rom_en_a; cur_valid = out_valid_a; cur_busy = busy_a;
    cur_addr = 5'(rom_addr_a); cur_x = 512'(x_flat_a);
    if (sel == 1) begin
      cur_en = rom_en_b; cur_valid = out_valid_b; cur_busy = busy_b;
      cur_addr = 5'(rom_addr_b); cur_x = x_flat_b;
    end else if (sel == 2) begin
      cur_en = rom_en_c; cur_valid = out_valid_c; cur_busy = busy_c;
      cur_addr = rom_addr_c; cur_x = 512'(x_flat_c);
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h (sel %0d, t=%0t)", name, act, exp, sel, $time);
    end
  endtask

  task automatic check_x(input string name, input logic [511:0] exp);
    n_checks++;
    if (cur_x !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, cur_x, exp);
    end
  endtask

  function automatic int rev_bits(input int k, input int bits);
    int r = 0;
    for (int i = 0; i < bits; i++) r = (r << 1) | ((k >> i) & 1);
    return r;
  endfunction

  // Start one frame, check the address stream and handshake timing, then score all slots.
  task automatic run_frame(input int s, input int n, input int aw, input bit sgn,
                           input logic [4:0] b, input bit br, input int hold);
    logic [31:0]  exp_slots[64];
    logic [511:0] snap;
    int           mask = (1 << aw) - 1;
    int           lg = $clog2(n);
    for (int k = 0; k < n; k++) begin
      logic [7:0]  sv = rom_word(5'((int'(b) + k) & mask)) & 16'h00FF;
      logic [23:0] ext = (sgn && sv[7]) ? {16'hFFFF, sv} : {16'h0000, sv};
      exp_slots[br ? rev_bits(k, lg) : k] = {ext, 8'h00};
    end
    for (int i = 0; i < n; i++) exp_q.push_back(exp_slots[i]);
    sel = s; base = b; bitrev = br; out_ready = (hold == 0);
    start = 1'b1;
    tick();
    start = 1'b0;
    check("busy_after_start", 64'(cur_busy), 64'd1);
    check("rom_en_word0", 64'(cur_en), 64'd1);
    check("rom_addr_word0", 64'(cur_addr), 64'(int'(b) & mask));
    for (int k = 1; k < n; k++) begin
      tick();
      check("rom_en_fetch", 64'(cur_en), 64'd1);
      check("rom_addr_seq", 64'(cur_addr), 64'((int'(b) + k) & mask));
    end
    tick();
    check("rom_en_last", 64'(cur_en), 64'd0);
    check("out_valid_early", 64'(cur_valid), 64'd0);
    tick();
    check("out_valid_rise", 64'(cur_valid), 64'd1);
    for (int i = 0; i < n; i++) begin
      if (exp_q.size() == 0) check("scoreboard_underflow", 64'd1, 64'd0);
      else check($sformatf("slot%0d", i), 64'(cur_x[i*32 +: 32]), 64'(exp_q.pop_front()));
    end
    snap = cur_x;
    for (int h = 0; h < hold; h++) begin
      start = (h == 2);
      tick();
      start = 1'b0;
      check("hold_out_valid", 64'(cur_valid), 64'd1);
      check("hold_rom_en", 64'(cur_en), 64'd0);
      check("hold_busy", 64'(cur_busy), 64'd1);
      check_x("hold_x_stable", snap);
    end
    out_ready = 1'b1;
    tick();
    check("accept_out_valid", 64'(cur_valid), 64'd0);
    check("accept_busy", 64'(cur_busy), 64'd0);
    check_x("x_kept_after_accept", snap);
  endtask

  typedef struct {
    int          s;
    int          n;
    int          aw;
    bit          sgn;
    logic [4:0]  b;
    bit          br;
    int          hold;
    int          slot;
    logic [31:0] exp;
  } vec_t;

  vec_t vecs[10];

  initial begin
    vecs[0] = '{0, 8, 3, 1'b0, 5'd0,  1'b0, 0, 0, 32'h00001000};
    vecs[1] = '{0, 8, 3, 1'b0, 5'd0,  1'b0, 0, 7, 32'h00001700};
    vecs[2] = '{0, 8, 3, 1'b0, 5'd0,  1'b1, 0, 1, 32'h00001400};
    vecs[3] = '{0, 8, 3, 1'b0, 5'd0,  1'b1, 0, 3, 32'h00001600};
    vecs[4] = '{0, 8, 3, 1'b0, 5'd0,  1'b1, 0, 6, 32'h00001300};
    vecs[5] = '{1, 16, 4, 1'b0, 5'd14, 1'b0, 0, 0, 32'h00001E00};
    vecs[6] = '{1, 16, 4, 1'b0, 5'd14, 1'b0, 0, 2, 32'h00001000};
    vecs[7] = '{2, 2, 5, 1'b1, 5'h1E, 1'b0, 0, 0, 32'hFFFF8000};
    vecs[8] = '{2, 2, 5, 1'b1, 5'h1E, 1'b0, 0, 1, 32'h00007F00};
    vecs[9] = '{0, 8, 3, 1'b0, 5'd5,  1'b1, 5, 0, 32'h00001500};

    reset_n = 1'b0; start = 1'b0; bitrev = 1'b0; out_ready = 1'b0; base = '0; sel = 0;
    tick(); tick();
    for (int s = 0; s < 3; s++) begin
      sel = s;
      #1;
      check("reset_rom_en", 64'(cur_en), 64'd0);
      check("reset_rom_addr", 64'(cur_addr), 64'd0);
      check("reset_out_valid", 64'(cur_valid), 64'd0);
      check("reset_busy", 64'(cur_busy), 64'd0);
      check_x("reset_x_flat", '0);
    end
    reset_n = 1'b1;
    tick();

    for (int v = 0; v < 10; v++) begin
      run_frame(vecs[v].s, vecs[v].n, vecs[v].aw, vecs[v].sgn, vecs[v].b, vecs[v].br, vecs[v].hold);
      check($sformatf("vec%0d_slot%0d", v, vecs[v].slot), 64'(cur_x[vecs[v].slot*32 +: 32]),
            64'(vecs[v].exp));
    end

    for (int r = 0; r < 4; r++) begin
      int s = $urandom_range(0, 1);
      run_frame(s, s ? 16 : 8, s ? 4 : 3, 1'b0, 5'($urandom_range(0, 15)),
                1'($urandom_range(0, 1)), $urandom_range(0, 3));
    end

    // Reset while word 3 is addressed, then a clean N=16 frame.
    sel = 1; base = '0; bitrev = 1'b0; out_ready = 1'b1;
    start = 1'b1;
    tick();
    start = 1'b0;
    tick(); tick(); tick();
    check("midfetch_addr3", 64'(cur_addr), 64'd3);
    reset_n = 1'b0;
    tick();
    check("midreset_rom_en", 64'(cur_en), 64'd0);
    check("midreset_rom_addr", 64'(cur_addr), 64'd0);
    check("midreset_out_valid", 64'(cur_valid), 64'd0);
    check("midreset_busy", 64'(cur_busy), 64'd0);
    check_x("midreset_x_flat", '0);
    reset_n = 1'b1;
    tick();
    check("post_reset_no_valid", 64'(cur_valid), 64'd0);
    run_frame(1, 16, 4, 1'b0, 5'd0, 1'b0, 0);

    check("scoreboard_empty", 64'(exp_q.size()), 64'd0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
